// File: rtl/bfly_feed_if.sv
// Stream bundle between the beat source, the butterfly feeder and the butterfly consumer.
// The master modport is the source/consumer side and the slave modport is the feeder itself.
interface bfly_feed_if #(
  parameter int WIDTH    = 12,
  parameter int NUM_PAIR = 16,
  parameter int DEPTH    = 4
);
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: a beat is taken on every rising edge where din_valid is high. There is no
  // ready, so the feeder never stalls the source. The consumer must take every beat that
  // has bfly_valid high.
  logic                                     din_valid;
  logic signed [NUM_PAIR-1:0][WIDTH-1:0]    din_re;
  logic signed [NUM_PAIR-1:0][WIDTH-1:0]    din_im;
  logic                                     bfly_valid;
  logic signed [NUM_PAIR-1:0][WIDTH-1:0]    bfly_din_re;
  logic signed [NUM_PAIR-1:0][WIDTH-1:0]    bfly_din_im;
  logic signed [NUM_PAIR-1:0][WIDTH-1:0]    shift_data_re;
  logic signed [NUM_PAIR-1:0][WIDTH-1:0]    shift_data_im;
  logic [CW-1:0]                            pair_idx;
  logic                                     frame_done;
  logic                                     fill_busy;
  logic                                     err_sticky;
  logic                                     fsm_state;

  modport master (
    output din_valid, din_re, din_im,
    input  bfly_valid, bfly_din_re, bfly_din_im, shift_data_re, shift_data_im,
           pair_idx, frame_done, fill_busy, err_sticky, fsm_state
  );

  modport slave (
    input  din_valid, din_re, din_im,
    output bfly_valid, bfly_din_re, bfly_din_im, shift_data_re, shift_data_im,
           pair_idx, frame_done, fill_busy, err_sticky, fsm_state
  );
endinterface

// File: rtl/bfly_feed.sv
// Radix-2 butterfly feeder. It buffers the first half-frame and then pairs each buffered beat
// with the matching live beat from the second half-frame.
module bfly_feed #(
  parameter int WIDTH    = 12,
  parameter int NUM_PAIR = 16,
  parameter int DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  bfly_feed_if.slave  bus
);
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic signed [NUM_PAIR-1:0][WIDTH-1:0] beat_t;
  typedef enum logic {FILL = 1'b0, PAIR = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          buf_we;
  logic          out_valid_d;
  logic          done_d;
  logic          last_beat;

  beat_t buf_re [DEPTH];
  beat_t buf_im [DEPTH];

  assign last_beat     = (cnt_q == CW'(DEPTH - 1));
  assign bus.fsm_state = state_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    buf_we      = 1'b0;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    if (bus.din_valid) begin
      cnt_d = last_beat ? '0 : cnt_q + CW'(1);
      case (state_q)
        FILL: begin
          buf_we = 1'b1;
          if (last_beat) state_d = PAIR;
        end
        PAIR: begin
          out_valid_d = 1'b1;
          if (last_beat) begin
            done_d  = 1'b1;
            state_d = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // The buffer has no reset. Its contents only matter after a complete FILL.
  always_ff @(posedge clk) begin
    if (!rst && !flush && buf_we) begin
      buf_re[cnt_q] <= bus.din_re;
      buf_im[cnt_q] <= bus.din_im;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q           <= FILL;
      cnt_q             <= '0;
      bus.fill_busy     <= 1'b1;
      bus.bfly_valid    <= 1'b0;
      bus.frame_done    <= 1'b0;
      bus.pair_idx      <= '0;
      bus.bfly_din_re   <= '0;
      bus.bfly_din_im   <= '0;
      bus.shift_data_re <= '0;
      bus.shift_data_im <= '0;
      if (rst)
        bus.err_sticky <= 1'b0;
      else if (cnt_q != '0 || state_q == PAIR)
        bus.err_sticky <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bus.fill_busy  <= (state_d == FILL);
      bus.bfly_valid <= out_valid_d;
      bus.frame_done <= done_d;
      if (out_valid_d) begin
        bus.pair_idx      <= cnt_q;
        bus.bfly_din_re   <= bus.din_re;
        bus.bfly_din_im   <= bus.din_im;
        bus.shift_data_re <= buf_re[cnt_q];
        bus.shift_data_im <= buf_im[cnt_q];
      end else begin
        bus.pair_idx      <= '0;
        bus.bfly_din_re   <= '0;
        bus.bfly_din_im   <= '0;
        bus.shift_data_re <= '0;
        bus.shift_data_im <= '0;
      end
    end
  end
endmodule

// File: tb/tb_bfly_feed.sv
// Bench for bfly_feed. A frame-level reference model tracks accepted beats and predicts every
// output one cycle ahead.
module tb_bfly_feed;
  localparam int W  = 12;
  localparam int NP = 16;
  localparam int D  = 4;
  localparam int CW = $clog2(D);

  typedef logic signed [NP-1:0][W-1:0] beat_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  bfly_feed_if #(.WIDTH(W), .NUM_PAIR(NP), .DEPTH(D)) bus();

  bfly_feed #(.WIDTH(W), .NUM_PAIR(NP), .DEPTH(D)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus.slave)
  );

  // Reference model: beats accepted so far in the current frame, plus the stored first half.
  int      n_acc;
  beat_t   half_re [D];
  beat_t   half_im [D];
  logic    e_valid, e_done, e_busy, e_err;
  logic [CW-1:0] e_idx;
  beat_t   e_dre, e_dim, e_sre, e_sim;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_din_q[$];

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string tag, input logic [NP*W-1:0] obs, input logic [NP*W-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic beat_t rnd_beat();
    beat_t b;
    for (int l = 0; l < NP; l++) b[l] = W'($urandom);
    return b;
  endfunction

  function automatic beat_t fill_beat(input logic [W-1:0] v);
    beat_t b;
    for (int l = 0; l < NP; l++) b[l] = v;
    return b;
  endfunction

  function automatic beat_t lane0_beat(input int v);
    beat_t b;
    b = rnd_beat();
    b[0] = W'(v);
    return b;
  endfunction

  task automatic model_step(input logic v, input logic f, input logic r, input beat_t re, input beat_t im);
    int k;
    e_valid = 1'b0; e_done = 1'b0; e_idx = '0;
    e_dre = '0; e_dim = '0; e_sre = '0; e_sim = '0;
    if (r) begin
      n_acc = 0;
      e_err = 1'b0;
    end else if (f) begin
      if (n_acc != 0) e_err = 1'b1;
      n_acc = 0;
    end else if (v) begin
      if (n_acc < D) begin
        half_re[n_acc] = re;
        half_im[n_acc] = im;
      end else begin
        k = n_acc - D;
        e_valid = 1'b1;
        e_idx   = CW'(k);
        e_done  = (k == D - 1);
        e_dre = re; e_dim = im;
        e_sre = half_re[k]; e_sim = half_im[k];
      end
      n_acc = (n_acc + 1) % (2 * D);
    end
    e_busy = (n_acc < D);
  endtask

  task automatic cycle(input logic v, input logic f, input logic r, input beat_t re, input beat_t im);
    logic [W-1:0] q;
    rst = r; flush = f;
    bus.din_valid = v; bus.din_re = re; bus.din_im = im;
    model_step(v, f, r, re, im);
    @(posedge clk);
    @(negedge clk);
    chk("bfly_valid", NP*W'(bus.bfly_valid), NP*W'(e_valid));
    chk("frame_done", NP*W'(bus.frame_done), NP*W'(e_done));
    chk("fill_busy",  NP*W'(bus.fill_busy),  NP*W'(e_busy));
    chk("err_sticky", NP*W'(bus.err_sticky), NP*W'(e_err));
    chk("pair_idx",   NP*W'(bus.pair_idx),   NP*W'(e_idx));
    chk("bfly_din_re",   bus.bfly_din_re,   e_dre);
    chk("bfly_din_im",   bus.bfly_din_im,   e_dim);
    chk("shift_data_re", bus.shift_data_re, e_sre);
    chk("shift_data_im", bus.shift_data_im, e_sim);
    if (bus.bfly_valid && exp_q.size() > 0) begin
      q = exp_q.pop_front();
      chk("plan_shift_lane0", NP*W'(bus.shift_data_re[0]), NP*W'(q));
      q = exp_din_q.pop_front();
      chk("plan_din_lane0", NP*W'(bus.bfly_din_re[0]), NP*W'(q));
    end
  endtask

  initial begin
    n_acc = 0; e_err = 1'b0;
    rst = 1'b1; flush = 1'b0;
    bus.din_valid = 1'b0; bus.din_re = '0; bus.din_im = '0;

    // Reset state
    cycle(1'b0, 1'b0, 1'b1, '0, '0);

    // Plain frame: lane0 re=1..8, im=-1..-8
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(W'(i));
      exp_din_q.push_back(W'(i + 4));
    end
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 1'b0, lane0_beat(i), lane0_beat(-i));
    cycle(1'b0, 1'b0, 1'b0, rnd_beat(), rnd_beat());
    chk("plan_queue_drained", NP*W'(exp_q.size()), '0);

    // Same stream with a gap after every beat
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 1'b0, 1'b0, lane0_beat(i), lane0_beat(-i));
      cycle(1'b0, 1'b0, 1'b0, rnd_beat(), rnd_beat());
    end

    // Three back-to-back frames
    for (int i = 0; i < 24; i++) cycle(1'b1, 1'b0, 1'b0, rnd_beat(), rnd_beat());

    // Extreme sample values
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 1'b0, 1'b0, fill_beat((i % 2) ? 12'h800 : 12'h7FF),
            fill_beat((i % 2) ? 12'h7FF : 12'h800));

    // Flush after two FILL beats, with a beat offered on the flush cycle
    cycle(1'b1, 1'b0, 1'b0, rnd_beat(), rnd_beat());
    cycle(1'b1, 1'b0, 1'b0, rnd_beat(), rnd_beat());
    cycle(1'b1, 1'b1, 1'b0, rnd_beat(), rnd_beat());
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, rnd_beat(), rnd_beat());

    // Reset while pair_idx=2 is on the outputs, then a fresh frame
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, rnd_beat(), rnd_beat());
    cycle(1'b1, 1'b1, 1'b1, rnd_beat(), rnd_beat());
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, rnd_beat(), rnd_beat());

    // Random traffic with gaps and occasional flushes
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0), 1'b0,
            rnd_beat(), rnd_beat());

    cycle(1'b0, 1'b0, 1'b1, '0, '0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
